// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer: FSM state encodings, default
// timing parameters and the width of the shifts-remaining counter.
package shift_sequencer_pkg;

   localparam int DEF_TICK_DIV    = 25000000;
   localparam int DEF_SHIFT_COUNT = 8;
   localparam int SHIFTS_W        = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A run is in progress while the FSM is in RUN or in the closing DONE cycle.
   function automatic logic is_busy_state(input state_e s);
      return (s == ST_RUN) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/status bundle between a controller (master) and the shift
// sequencer (slave).
//   load_req, start_req, step_req : one-cycle request pulses
//   abort                         : level, cancels a run in progress
//   load_en, shift_en             : registered strobes to the holding register
//   busy, done                    : run status, done is a one-cycle pulse
//   shifts_left                   : automatic shifts still to issue
//   state_dbg                     : current FSM state encoding
interface shift_sequencer_if;
   import shift_sequencer_pkg::*;

   logic                load_req;
   logic                start_req;
   logic                step_req;
   logic                abort;
   logic                load_en;
   logic                shift_en;
   logic                busy;
   logic                done;
   logic [SHIFTS_W-1:0] shifts_left;
   logic [1:0]          state_dbg;

   modport master (
      output load_req, start_req, step_req, abort,
      input  load_en, shift_en, busy, done, shifts_left, state_dbg
   );

   modport slave (
      input  load_req, start_req, step_req, abort,
      output load_en, shift_en, busy, done, shifts_left, state_dbg
   );

endinterface

// File: rtl/shift_sequencer_tick_gen.sv
// tick_gen: free-running divider used while a run is active.
//   clk, btn_reset : clock and asynchronous active-high reset
//   clear          : forces the count to zero (has priority over enable)
//   enable         : count one step per cycle
//   tick           : high during the cycle the count equals TICK_DIV-1
module tick_gen
   import shift_sequencer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic btn_reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // tick is combinational so the sequencer can register shift_en on the
   // same edge that wraps the counter.
   assign tick = enable && (cnt_q == CNT_LAST);

   // Next count: clear wins, otherwise wrap at TICK_DIV-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable) begin
         if (tick) begin
            cnt_d = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge btn_reset) begin
      if (btn_reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives load/shift strobes for an external holding
// register, either on single requests or as an automatic run of SHIFT_COUNT
// shifts spaced TICK_DIV cycles apart.
//   clk       : rising-edge clock
//   btn_reset : asynchronous active-high reset
//   bus       : request inputs and registered status outputs (slave side)
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int SHIFT_COUNT = DEF_SHIFT_COUNT
) (
   input  logic               clk,
   input  logic               btn_reset,
   shift_sequencer_if.slave   bus
);

   state_e              state_q;
   state_e              state_d;
   logic                load_en_q;
   logic                load_en_d;
   logic                shift_en_q;
   logic                shift_en_d;
   logic                busy_q;
   logic                busy_d;
   logic                done_q;
   logic                done_d;
   logic [SHIFTS_W-1:0] shifts_left_q;
   logic [SHIFTS_W-1:0] shifts_left_d;

   logic                tick;
   logic                tick_clear;
   logic                tick_enable;

   // The divider only runs in RUN and is held at zero otherwise, so every
   // run starts from a cleared count.
   assign tick_enable = (state_q == ST_RUN);
   assign tick_clear  = (state_q != ST_RUN);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk       (clk),
      .btn_reset (btn_reset),
      .clear     (tick_clear),
      .enable    (tick_enable),
      .tick      (tick)
   );

   // Next-state and next-output logic. Requests are only honoured in IDLE;
   // in RUN and DONE they are dropped rather than queued.
   always_comb begin
      state_d       = state_q;
      load_en_d     = 1'b0;
      shift_en_d    = 1'b0;
      done_d        = 1'b0;
      shifts_left_d = shifts_left_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load_req) begin
               load_en_d = 1'b1;
            end else if (bus.start_req) begin
               state_d       = ST_RUN;
               shifts_left_d = SHIFTS_W'(SHIFT_COUNT);
            end else if (bus.step_req) begin
               shift_en_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               // Abort also suppresses a shift that would coincide with it.
               state_d       = ST_IDLE;
               shifts_left_d = {SHIFTS_W{1'b0}};
            end else if (shifts_left_q == {SHIFTS_W{1'b0}}) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (tick) begin
               shift_en_d    = 1'b1;
               shifts_left_d = shifts_left_q - SHIFTS_W'(1);
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            // Unused encoding: fall back to a clean IDLE.
            state_d       = ST_IDLE;
            shifts_left_d = {SHIFTS_W{1'b0}};
         end
      endcase
      busy_d = is_busy_state(state_d);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge btn_reset) begin
      if (btn_reset) begin
         state_q       <= ST_IDLE;
         load_en_q     <= 1'b0;
         shift_en_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         shifts_left_q <= {SHIFTS_W{1'b0}};
      end else begin
         state_q       <= state_d;
         load_en_q     <= load_en_d;
         shift_en_q    <= shift_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         shifts_left_q <= shifts_left_d;
      end
   end

   assign bus.load_en     = load_en_q;
   assign bus.shift_en    = shift_en_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.shifts_left = shifts_left_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with TICK_DIV=4, SHIFT_COUNT=8.
module tb_shift_sequencer;
   import shift_sequencer_pkg::*;

   logic clk       = 1'b0;
   logic btn_reset = 1'b0;
   int   n_vec     = 0;
   int   n_fail    = 0;

   shift_sequencer_if bus ();

   shift_sequencer #(
      .TICK_DIV    (4),
      .SHIFT_COUNT (8)
   ) dut (
      .clk       (clk),
      .btn_reset (btn_reset),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic       st;
      logic       sp;
      logic       ab;
      logic       e_load;
      logic       e_shift;
      logic [1:0] e_state;
      string      name;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock; sample just after the edge and check the per-cycle invariants.
   task automatic tick1();
      @(posedge clk);
      #1;
      chk("excl_load_shift", 32'(bus.load_en & bus.shift_en), 32'd0);
      chk("busy_vs_state", 32'(bus.busy),
          32'((bus.state_dbg == 2'd1) || (bus.state_dbg == 2'd2)));
   endtask

   task automatic run_count(input int n, output int s, output int d, output int l);
      s = 0;
      d = 0;
      l = 0;
      repeat (n) begin
         tick1();
         s += int'(bus.shift_en);
         d += int'(bus.done);
         l += int'(bus.load_en);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_load_en"}, 32'(bus.load_en), 32'd0);
      chk({tag, "_shift_en"}, 32'(bus.shift_en), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_shifts_left"}, 32'(bus.shifts_left), 32'd0);
      chk({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   initial begin
      int s;
      int d;
      int l;
      int seen;
      logic e_shift;
      int   e_left;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "none"};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "load"};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, "step"};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "load_step"};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "load_start_step"};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "abort_step_idle"};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "start"};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, "start_step"};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "abort_load_idle"};

      bus.load_req  = 1'b0;
      bus.start_req = 1'b0;
      bus.step_req  = 1'b0;
      bus.abort     = 1'b0;

      // Reset state, before any clock edge and while held across edges.
      #1 btn_reset = 1'b1;
      #1;
      chk_all_zero("reset_async");
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_held");
      @(negedge clk);
      btn_reset = 1'b0;
      repeat (2) tick1();

      // Full automatic run, cycle-exact: i counts cycles after the start edge.
      bus.start_req = 1'b1;
      tick1();
      bus.start_req = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         e_shift = (i >= 5) && (i <= 33) && (((i - 5) % 4) == 0);
         if (i < 5) begin
            e_left = 8;
         end else if (i <= 33) begin
            e_left = 8 - (((i - 5) / 4) + 1);
         end else begin
            e_left = 0;
         end
         chk($sformatf("run_shift_en_c%0d", i), 32'(bus.shift_en), 32'(e_shift));
         chk($sformatf("run_done_c%0d", i), 32'(bus.done), 32'(i == 34));
         chk($sformatf("run_busy_c%0d", i), 32'(bus.busy), 32'(i <= 34));
         chk($sformatf("run_shifts_left_c%0d", i), 32'(bus.shifts_left), 32'(e_left));
         tick1();
      end

      // Single-cycle requests in IDLE: priority, pulse width, state.
      for (int v = 0; v < 9; v++) begin
         bus.load_req  = vecs[v].ld;
         bus.start_req = vecs[v].st;
         bus.step_req  = vecs[v].sp;
         bus.abort     = vecs[v].ab;
         tick1();
         bus.load_req  = 1'b0;
         bus.start_req = 1'b0;
         bus.step_req  = 1'b0;
         bus.abort     = 1'b0;
         chk({vecs[v].name, "_load_en"}, 32'(bus.load_en), 32'(vecs[v].e_load));
         chk({vecs[v].name, "_shift_en"}, 32'(bus.shift_en), 32'(vecs[v].e_shift));
         chk({vecs[v].name, "_state"}, 32'(bus.state_dbg), 32'(vecs[v].e_state));
         tick1();
         chk({vecs[v].name, "_pulse_end"}, 32'(bus.load_en | bus.shift_en), 32'd0);
         chk({vecs[v].name, "_state_hold"}, 32'(bus.state_dbg), 32'(vecs[v].e_state));
         if (vecs[v].e_state == 2'd1) begin
            bus.abort = 1'b1;
            tick1();
            bus.abort = 1'b0;
            chk({vecs[v].name, "_abort_recover"}, 32'(bus.state_dbg), 32'd0);
         end
      end

      // Abort after the third shift of a run.
      bus.start_req = 1'b1;
      tick1();
      bus.start_req = 1'b0;
      seen = 0;
      for (int i = 0; (i < 40) && (seen < 3); i++) begin
         tick1();
         if (bus.shift_en) seen++;
      end
      chk("abort_seen3", 32'(seen), 32'd3);
      bus.abort = 1'b1;
      tick1();
      bus.abort = 1'b0;
      chk("abort_state", 32'(bus.state_dbg), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_shifts_left", 32'(bus.shifts_left), 32'd0);
      chk("abort_shift_en", 32'(bus.shift_en), 32'd0);
      run_count(40, s, d, l);
      chk("abort_total_shifts", 32'(seen + s), 32'd3);
      chk("abort_no_done", 32'(d), 32'd0);

      // Requests sprinkled through RUN and DONE are ignored.
      bus.start_req = 1'b1;
      tick1();
      bus.start_req = 1'b0;
      s = 0;
      d = 0;
      l = 0;
      for (int i = 1; i < 45; i++) begin
         bus.step_req  = (i == 7) || (i == 34);
         bus.load_req  = (i == 12);
         bus.start_req = (i == 20);
         tick1();
         bus.step_req  = 1'b0;
         bus.load_req  = 1'b0;
         bus.start_req = 1'b0;
         s += int'(bus.shift_en);
         d += int'(bus.done);
         l += int'(bus.load_en);
      end
      chk("reqs_in_run_shifts", 32'(s), 32'd8);
      chk("reqs_in_run_loads", 32'(l), 32'd0);
      chk("reqs_in_run_done", 32'(d), 32'd1);
      chk("reqs_in_run_state", 32'(bus.state_dbg), 32'd0);

      // Reset between edges mid-run, then a fresh full run.
      bus.start_req = 1'b1;
      tick1();
      bus.start_req = 1'b0;
      repeat (9) tick1();
      #3 btn_reset = 1'b1;
      #1;
      chk_all_zero("midrun_reset");
      @(posedge clk);
      #2;
      chk_all_zero("midrun_reset_edge");
      @(negedge clk);
      btn_reset = 1'b0;
      bus.start_req = 1'b1;
      tick1();
      bus.start_req = 1'b0;
      chk("post_reset_start_state", 32'(bus.state_dbg), 32'd1);
      chk("post_reset_shifts_left", 32'(bus.shifts_left), 32'd8);
      run_count(44, s, d, l);
      chk("post_reset_shifts", 32'(s), 32'd8);
      chk("post_reset_done", 32'(d), 32'd1);
      chk("post_reset_idle", 32'(bus.state_dbg), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
